// File: rtl/bsg_lfsr_pkg.sv
// Shared Galois LFSR definitions: maximal-length tap masks and the single-step
// feedback function used by every LFSR width in the library.
package bsg_lfsr_pkg;

  // Widest state the shared step function handles.
  localparam int unsigned lfsr_max_width_lp = 64;

  typedef logic [lfsr_max_width_lp-1:0] lfsr_word_t;

  // Maximal-length right-shifting Galois tap masks, indexed by width.
  // Unsupported widths return zero so the caller must supply its own mask.
  function automatic lfsr_word_t max_taps(input int unsigned width);
    case (width)
      4:       return 64'h0000_000C;
      5:       return 64'h0000_0014;
      6:       return 64'h0000_0030;
      7:       return 64'h0000_0060;
      8:       return 64'h0000_00B8;
      9:       return 64'h0000_0110;
      10:      return 64'h0000_0240;
      11:      return 64'h0000_0500;
      12:      return 64'h0000_0829;
      13:      return 64'h0000_100D;
      14:      return 64'h0000_2015;
      15:      return 64'h0000_6000;
      16:      return 64'h0000_B400;
      17:      return 64'h0001_2000;
      18:      return 64'h0002_0400;
      19:      return 64'h0004_0023;
      20:      return 64'h0009_0000;
      21:      return 64'h0014_0000;
      22:      return 64'h0030_0000;
      23:      return 64'h0042_0000;
      24:      return 64'h00E1_0000;
      25:      return 64'h0120_0000;
      26:      return 64'h0200_0023;
      27:      return 64'h0400_0013;
      28:      return 64'h0900_0000;
      29:      return 64'h1400_0000;
      30:      return 64'h2000_0029;
      31:      return 64'h4800_0000;
      32:      return 64'h8020_0003;
      default: return '0;
    endcase
  endfunction

  // One Galois step. Because s and taps are zero above the LFSR width, the
  // right shift never pulls bits in from outside it, so one function serves
  // every width.
  function automatic lfsr_word_t galois_step(input lfsr_word_t s, input lfsr_word_t taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/bsg_lfsr_step.sv
// Combinational LFSR advance: steps_p single Galois steps chained in one cycle.
module bsg_lfsr_step
  import bsg_lfsr_pkg::*;
#(
  parameter int unsigned          width_p = 16,
  parameter logic [width_p-1:0]   taps_p  = width_p'(16'hB400),
  parameter int unsigned          steps_p = 1
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  logic [width_p-1:0] chain [steps_p+1];

  assign chain[0] = i;

  for (genvar k = 0; k < steps_p; k++) begin : g_step
    assign chain[k+1] = width_p'(galois_step(lfsr_word_t'(chain[k]), lfsr_word_t'(taps_p)));
  end

  assign o = chain[steps_p];

endmodule

// File: rtl/bsg_lfsr_gen.sv
// Parametrised Galois LFSR word source with runtime reseed, zero-seed
// protection and period-wrap detection; consumer advances it with yumi_i.
module bsg_lfsr_gen
  import bsg_lfsr_pkg::*;
#(
  parameter int unsigned        width_p = 16,
  parameter logic [width_p-1:0] taps_p  = width_p'(max_taps(width_p)),
  parameter logic [width_p-1:0] seed_p  = width_p'(1),
  parameter int unsigned        steps_p = 1
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               seed_v_i,
  input  logic [width_p-1:0] seed_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] o,
  output logic               wrap_o,
  output logic               err_o
);

  if (width_p < 2 || width_p > lfsr_max_width_lp) begin : g_bad_width
    $error("bsg_lfsr_gen: width_p must be in 2..%0d", lfsr_max_width_lp);
  end
  if (seed_p == '0) begin : g_bad_seed
    $error("bsg_lfsr_gen: seed_p must be nonzero");
  end
  if (steps_p < 1 || steps_p > width_p) begin : g_bad_steps
    $error("bsg_lfsr_gen: steps_p must be in 1..width_p");
  end

  logic [width_p-1:0] seed_r;
  logic [width_p-1:0] advance;

  bsg_lfsr_step #(
    .width_p (width_p),
    .taps_p  (taps_p),
    .steps_p (steps_p)
  ) step_u (
    .i (o),
    .o (advance)
  );

  // Priority: reset > seed load > advance > hold. A zero seed request falls
  // back to seed_p so the all-zero lock-up state can never be loaded.
  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than in the sensitivity list; all state uses non-blocking <=.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      o      <= seed_p;
      seed_r <= seed_p;
      wrap_o <= 1'b0;
      err_o  <= 1'b0;
    end else if (seed_v_i) begin
      wrap_o <= 1'b0;
      if (seed_i != '0) begin
        o      <= seed_i;
        seed_r <= seed_i;
      end else begin
        o      <= seed_p;
        seed_r <= seed_p;
        err_o  <= 1'b1;
      end
    end else if (yumi_i) begin
      o      <= advance;
      // Compare against the active seed so wraps track runtime reseeds.
      wrap_o <= (advance == seed_r);
    end else begin
      wrap_o <= 1'b0;
    end
  end

endmodule
